// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the 32-bit load/store initiator.
// Byte-lane masks and size encodings are used by the FSM and the lane merger.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] base;
    case (size)
      SZ_BYTE: base = 4'b0001;
      SZ_HALF: base = 4'b0011;
      SZ_WORD: base = 4'b1111;
      default: base = 4'b0000;
    endcase
    return 4'(base << off);
  endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Byte-lane steering: merges store data into an old word and extracts/extends load data.
// The offset must already be reduced to the lane width of the access.
module mem_lane_merge
  import mem_access_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        is_unsigned,
  output logic [31:0] merged,
  output logic [31:0] load_value
);

  logic [3:0]  mask;
  logic [31:0] shifted_new;
  logic [31:0] shifted_old;

  always_comb begin
    mask        = lane_mask(size, off);
    shifted_new = new_data << {off, 3'b000};
    shifted_old = old_word >> {off, 3'b000};
    merged      = old_word;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) merged[8*i +: 8] = shifted_new[8*i +: 8];
    end
    case (size)
      SZ_BYTE: load_value = {{24{~is_unsigned & shifted_old[7]}}, shifted_old[7:0]};
      SZ_HALF: load_value = {{16{~is_unsigned & shifted_old[15]}}, shifted_old[15:0]};
      default: load_value = shifted_old;
    endcase
  end

endmodule

// File: rtl/mem_access_initiator32.sv
// Core-side load/store initiator for a word-only memory responder.
// Sub-word stores are done as read-modify-write of the containing word.
module mem_access_initiator32
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic              resp_exception,
  output logic [ADDR_W-1:0] out_read_address,
  input  logic [31:0]       in_read_data,
  input  logic              in_read_exception,
  output logic              out_write_enable,
  output logic [ADDR_W-1:0] out_write_address,
  output logic [31:0]       out_write_data,
  input  logic              in_write_exception
);

  state_t              state_q, state_d;
  logic [1:0]          off_q, off_d;
  logic [1:0]          size_q, size_d;
  logic                store_q, store_d;
  logic                uns_q, uns_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wrdata_q, wrdata_d;
  logic [31:0]         rdata_out_q, rdata_out_d;
  logic                exc_q, exc_d;

  logic [ADDR_W-1:0]   word_addr;
  logic [1:0]          eff_off;
  logic                misaligned;
  logic [31:0]         merged;
  logic [31:0]         load_value;

  assign word_addr = {req_addr[ADDR_W-1:2], 2'b00};

  // Offset reduced to the lane width, so unchecked misaligned accesses stay in the word.
  always_comb begin
    case (req_size)
      SZ_HALF: eff_off = {req_addr[1], 1'b0};
      SZ_WORD: eff_off = 2'b00;
      default: eff_off = req_addr[1:0];
    endcase
    misaligned = (req_size == SZ_RSVD) ||
                 (CHECK_ALIGN && ((req_size == SZ_HALF && req_addr[0]) ||
                                  (req_size == SZ_WORD && req_addr[1:0] != 2'b00)));
  end

  mem_lane_merge u_lane_merge (
    .old_word   (in_read_data),
    .new_data   (wdata_q),
    .size       (size_q),
    .off        (off_q),
    .is_unsigned(uns_q),
    .merged     (merged),
    .load_value (load_value)
  );

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    size_d      = size_q;
    store_d     = store_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    raddr_d     = raddr_q;
    waddr_d     = waddr_q;
    wrdata_d    = wrdata_q;
    rdata_out_d = rdata_out_q;
    exc_d       = exc_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          off_d       = eff_off;
          size_d      = req_size;
          store_d     = req_store;
          uns_d       = req_unsigned;
          wdata_d     = req_wdata;
          rdata_out_d = 32'h0;
          exc_d       = 1'b0;
          if (misaligned) begin
            exc_d   = 1'b1;
            state_d = RESP;
          end else if (req_store && req_size == SZ_WORD) begin
            waddr_d  = word_addr;
            wrdata_d = req_wdata;
            state_d  = WRITE;
          end else begin
            raddr_d = word_addr;
            state_d = READ;
          end
        end
      end
      READ: begin
        if (!store_q) begin
          exc_d       = in_read_exception;
          rdata_out_d = in_read_exception ? 32'h0 : load_value;
          state_d     = RESP;
        end else if (in_read_exception) begin
          exc_d   = 1'b1;
          state_d = RESP;
        end else begin
          waddr_d  = raddr_q;
          wrdata_d = merged;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        exc_d   = in_write_exception;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      off_q       <= 2'b00;
      size_q      <= SZ_BYTE;
      store_q     <= 1'b0;
      uns_q       <= 1'b0;
      wdata_q     <= 32'h0;
      raddr_q     <= '0;
      waddr_q     <= '0;
      wrdata_q    <= 32'h0;
      rdata_out_q <= 32'h0;
      exc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      size_q      <= size_d;
      store_q     <= store_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      raddr_q     <= raddr_d;
      waddr_q     <= waddr_d;
      wrdata_q    <= wrdata_d;
      rdata_out_q <= rdata_out_d;
      exc_q       <= exc_d;
    end
  end

  assign req_ready         = (state_q == IDLE);
  assign resp_valid        = (state_q == RESP);
  assign resp_data         = rdata_out_q;
  assign resp_exception    = exc_q;
  assign out_read_address  = raddr_q;
  assign out_write_enable  = (state_q == WRITE);
  assign out_write_address = waddr_q;
  assign out_write_data    = wrdata_q;

endmodule
